// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: loader state encoding and word-count helpers for the ccff chain loader.
package ccff_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;
  function automatic int ccff_nwords(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction
  function automatic int ccff_last_bits(input int chain_len, input int word_w);
    return chain_len - (ccff_nwords(chain_len, word_w) - 1) * word_w;
  endfunction
endpackage

// File: rtl/ccff_word_serializer.sv
// ccff_word_serializer: one-word buffer that turns host words into an LSB-first bit stream (clk, rst, clear, en, s_data/s_valid/s_ready in, bit_out/bit_valid out).
module ccff_word_serializer import ccff_loader_pkg::*; #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              bit_out,
  output logic              bit_valid
);
  localparam int NWORDS = ccff_nwords(CHAIN_LEN, WORD_W);
  localparam int LAST = ccff_last_bits(CHAIN_LEN, WORD_W);
  localparam int RW = $clog2(WORD_W);
  localparam int WW = $clog2(NWORDS + 1);
  logic [WORD_W-1:0] sr;
  logic [RW-1:0] rem;
  logic [WW-1:0] words;
  logic accept;
  // rem counts buffered bits not yet handed out; a new word is taken the cycle it reaches zero
  assign s_ready = en && rem == '0 && words < WW'(NWORDS);
  assign accept = s_ready && s_valid;
  assign bit_valid = rem != '0 || accept;
  assign bit_out = rem != '0 ? sr[0] : s_data[0];
  always_ff @(posedge clk)
    if (rst || clear) begin
      sr <= '0;
      rem <= '0;
      words <= '0;
    end else if (accept) begin
      sr <= s_data >> 1;
      rem <= words == WW'(NWORDS - 1) ? RW'(LAST - 1) : RW'(WORD_W - 1);
      words <= words + 1'b1;
    end else if (rem != '0) begin
      sr <= sr >> 1;
      rem <= rem - 1'b1;
    end
endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serializes host words onto ccff_head with a shift enable (prog_clk, prog_reset, start, s_data/s_valid/s_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, error); CCFF_READBACK_EN adds a verify pass.
module ccff_chain_loader import ccff_loader_pkg::*; #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int BW = $clog2(CHAIN_LEN + 1);
  state_t state;
  logic [BW-1:0] bit_cnt;
  logic bit_out, bit_valid, last_shift, active;
  assign active = state == LOAD || state == VERIFY;
  assign last_shift = ccff_shift_en && bit_cnt == BW'(CHAIN_LEN - 1);
  // the buffer is cleared outside a pass and at each pass boundary
  ccff_word_serializer #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) u_ser (
    .clk(prog_clk),
    .rst(prog_reset),
    .clear(!active || last_shift),
    .en(active),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .bit_out(bit_out),
    .bit_valid(bit_valid)
  );
`ifdef CCFF_READBACK_EN
  logic err_q, mis;
  // the tail shows the first-pass bit while the same bit is shifted in again
  assign mis = state == VERIFY && ccff_shift_en && ccff_tail != ccff_head;
  assign error = err_q | mis;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign error = 1'b0;
`endif
  always_ff @(posedge prog_clk)
    if (prog_reset) begin
      state <= IDLE;
      ccff_head <= 1'b0;
      ccff_shift_en <= 1'b0;
      bit_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
`ifdef CCFF_READBACK_EN
      err_q <= 1'b0;
`endif
    end else begin
      ccff_head <= bit_valid ? bit_out : ccff_head;
      ccff_shift_en <= bit_valid;
      bit_cnt <= (!active || last_shift) ? '0 : bit_cnt + BW'(ccff_shift_en);
      done <= 1'b0;
`ifdef CCFF_READBACK_EN
      if (mis) err_q <= 1'b1;
`endif
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          busy <= 1'b1;
`ifdef CCFF_READBACK_EN
          err_q <= 1'b0;
`endif
        end
        LOAD: if (last_shift) begin
`ifdef CCFF_READBACK_EN
          state <= VERIFY;
`else
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
`endif
        end
        VERIFY: if (last_shift) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: table-driven scoreboard bench for ccff_chain_loader (20/8 and 16/8 instances).
module tb_ccff_chain_loader;
`ifdef CCFF_READBACK_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, start, s_valid, s_ready, head, sh, busy, done, error, tail;
  logic [7:0] s_data;
  logic [19:0] chain;
  logic start2, v2, r2, h2, se2, b2, dn2, e2;
  logic [7:0] d2;
  int tests = 0, fails = 0;
  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut (
    .prog_clk(clk), .prog_reset(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .ccff_head(head), .ccff_shift_en(sh), .ccff_tail(tail),
    .busy(busy), .done(done), .error(error)
  );
  ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut2 (
    .prog_clk(clk), .prog_reset(rst), .start(start2), .s_data(d2), .s_valid(v2),
    .s_ready(r2), .ccff_head(h2), .ccff_shift_en(se2), .ccff_tail(1'b0),
    .busy(b2), .done(dn2), .error(e2)
  );
  assign tail = chain[19];
  always @(posedge clk) if (rst) chain <= '0; else if (sh) chain <= {chain[18:0], head};
  typedef struct {
    logic [7:0] w0, w1, w2;
    int gap;
    bit restart;
    logic [19:0] exp_bits;
    int exp_stall;
  } vec_t;
  vec_t v[4];
  logic q[$];
  int n_shift, n_stall, n_done, err_at, n2, acc2, nd2;
  logic [39:0] obs;
  logic [15:0] obs2;
  logic prev_head, seen;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (sh) begin
      n_shift++;
      seen = 1'b1;
      if (n_shift <= 40) obs[n_shift-1] = head;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL extra_shift: got shift %0d with empty scoreboard", n_shift);
      end else chk("head_bit", 64'(head), 64'(q.pop_front()));
    end else if (busy && seen) begin
      n_stall++;
      chk("stall_hold", 64'(head), 64'(prev_head));
    end
    if (error && err_at == 0) err_at = n_shift;
    if (done) begin
      n_done++;
      chk("busy_with_done", 64'(busy), 64'(0));
    end
    prev_head = head;
  end
  always @(negedge clk) begin
    if (se2) begin
      if (n2 < 16) obs2[n2] = h2;
      n2++;
    end
    if (v2 && r2) acc2++;
    if (dn2) nd2++;
  end
  task automatic send_word(input logic [7:0] w, input int used);
    logic r;
    int t = 0;
    s_data = w;
    s_valid = 1'b1;
    do begin
      @(negedge clk);
      r = s_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!r && t < 100);
    if (!r) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: word %0h not accepted in %0d cycles", w, t);
    end else for (int i = 0; i < used; i++) q.push_back(w[i]);
  endtask
  task automatic send_pass(input vec_t x, input logic [7:0] w1);
    send_word(x.w0, 8);
    start = x.restart;
    if (x.gap > 0) s_valid = 1'b0;
    repeat (x.gap > 0 ? 7 + x.gap : 1) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    send_word(w1, 8);
    send_word(x.w2, 4);
    s_valid = 1'b0;
  endtask
  task automatic begin_load();
    n_shift = 0; n_stall = 0; n_done = 0; err_at = 0; obs = '0; seen = 1'b0;
    q.delete();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask
  task automatic wait_done();
    int t = 0;
    while (n_done == 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (n_done == 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done after %0d cycles", t);
    end
  endtask
  task automatic run_vec(input vec_t x, input logic [7:0] w1b, input int passes);
    begin_load();
    send_pass(x, x.w1);
    if (passes == 2) send_pass(x, w1b);
    wait_done();
  endtask
  initial begin
    v[0] = '{8'hA5, 8'h3C, 8'hFF, 0, 1'b0, 20'hF3CA5, 0};
    v[1] = '{8'hA5, 8'h3C, 8'hFF, 5, 1'b0, 20'hF3CA5, 5};
    v[2] = '{8'h00, 8'hFF, 8'h0A, 0, 1'b0, 20'hAFF00, 0};
    v[3] = '{8'h5A, 8'hC3, 8'hF0, 2, 1'b1, 20'h0C35A, 2};
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
    start2 = 1'b0; v2 = 1'b0; d2 = '0;
    n2 = 0; acc2 = 0; nd2 = 0; obs2 = '0; prev_head = 1'b0; seen = 1'b0;
    n_shift = 0; n_stall = 0; n_done = 0; err_at = 0; obs = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_head", 64'(head), 64'(0));
    chk("rst_shift_en", 64'(sh), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_error", 64'(error), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_vec(v[i], v[i].w1, PASSES);
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("v%0d_shifts", i), 64'(n_shift), 64'(20 * PASSES));
      chk($sformatf("v%0d_done_cnt", i), 64'(n_done), 64'(1));
      chk($sformatf("v%0d_bits", i), 64'(obs[19:0]), 64'(v[i].exp_bits));
      chk($sformatf("v%0d_sb_empty", i), 64'(q.size()), 64'(0));
      chk($sformatf("v%0d_busy_after", i), 64'(busy), 64'(0));
      chk($sformatf("v%0d_error", i), 64'(error), 64'(0));
`ifdef CCFF_READBACK_EN
      chk($sformatf("v%0d_bits_pass2", i), 64'(obs[39:20]), 64'(v[i].exp_bits));
      chk($sformatf("v%0d_err_at", i), 64'(err_at), 64'(0));
`else
      chk($sformatf("v%0d_stall", i), 64'(n_stall), 64'(v[i].exp_stall));
`endif
    end
    begin_load();
    for (int i = 0; i < 8; i++) q.push_back(v[0].w0[i]);
    s_data = v[0].w0;
    s_valid = 1'b1;
    for (int t = 0; t < 50 && n_shift < 7; t++) begin
      @(posedge clk);
      #1;
    end
    chk("rst_mid_shifts", 64'(n_shift), 64'(7));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_s_ready", 64'(s_ready), 64'(0));
    chk("mid_rst_head", 64'(head), 64'(0));
    chk("mid_rst_shift_en", 64'(sh), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    chk("mid_rst_error", 64'(error), 64'(0));
    @(posedge clk);
    #1;
    run_vec(v[0], v[0].w1, PASSES);
    chk("reload_shifts", 64'(n_shift), 64'(20 * PASSES));
    chk("reload_bits", 64'(obs[19:0]), 64'(20'hF3CA5));
`ifdef CCFF_READBACK_EN
    run_vec(v[0], 8'h3D, 2);
    repeat (3) @(posedge clk);
    #1;
    chk("rb_error_set", 64'(error), 64'(1));
    chk("rb_err_at", 64'(err_at), 64'(29));
    chk("rb_shifts", 64'(n_shift), 64'(40));
    start = 1'b1;
    @(negedge clk);
    chk("rb_error_before_start", 64'(error), 64'(1));
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("rb_error_cleared", 64'(error), 64'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
`else
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    v2 = 1'b1;
    d2 = 8'h11;
    for (int t = 0; t < 50 && acc2 < 1; t++) begin
      @(posedge clk);
      #1;
    end
    d2 = 8'h22;
    for (int t = 0; t < 50 && acc2 < 2; t++) begin
      @(posedge clk);
      #1;
    end
    d2 = 8'h33;
    @(negedge clk);
    chk("x16_ready_third", 64'(r2), 64'(0));
    for (int t = 0; t < 60 && nd2 == 0; t++) begin
      @(posedge clk);
      #1;
    end
    v2 = 1'b0;
    chk("x16_accepted", 64'(acc2), 64'(2));
    chk("x16_shifts", 64'(n2), 64'(16));
    chk("x16_bits", 64'(obs2), 64'(16'h2211));
    chk("x16_done_cnt", 64'(nd2), 64'(1));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
